// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, alu_op,
// datapath mux selects and FSM state codes.
package multicycle_main_fsm_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: steps each instruction through
// fetch/decode/execute/writeback and drives the datapath selects, enables and alu_op.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic [1:0]         alu_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   pc_update, branch;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = illegal_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REGB;
        RegWrite   = 1'b0;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        illegal_d  = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_REGA;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_REGA;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset aborts the instruction: kill every enable, park selects on FETCH values.
        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            ResultSrc  = RES_ALURESULT;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
        end
    end

    assign PCWrite    = (branch & Zero) | pc_update;
    assign illegal_op = illegal_q;
    assign state_dbg  = STATE_W'(state_q);

endmodule
